// File: rtl/dc_derr_pkg.sv
// Shared definitions for the chroma DC diffusion-error store: lane offsets, FSM encoding, 3/4 split.
// The CLEAR state exists only when DC_DERR_CLEAR_EN is defined.
package dc_derr_pkg;

    localparam int unsigned ERR_W  = 8;
    localparam int unsigned DERR_W = 48;
    localparam int unsigned TERM_W = 32;

    localparam int unsigned DERR_U1_LSB = 0;
    localparam int unsigned DERR_U2_LSB = 8;
    localparam int unsigned DERR_U3_LSB = 16;
    localparam int unsigned DERR_V1_LSB = 24;
    localparam int unsigned DERR_V2_LSB = 32;
    localparam int unsigned DERR_V3_LSB = 40;

    localparam int unsigned TERM_U0_LSB = 0;
    localparam int unsigned TERM_U1_LSB = 8;
    localparam int unsigned TERM_V0_LSB = 16;
    localparam int unsigned TERM_V1_LSB = 24;

    localparam int unsigned PROD_W    = 10;
    localparam int unsigned SPLIT_MUL = 3;
    localparam int unsigned SPLIT_SHR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
`ifdef DC_DERR_CLEAR_EN
        ,
        ST_CLEAR = 2'd3
`endif
    } state_e;

    // 3/4 share of err3 carried left; floor via arithmetic shift of the 10-bit product.
    function automatic logic [ERR_W-1:0] split_left1(input logic [ERR_W-1:0] err3);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'($signed(err3)) * $signed(PROD_W'(SPLIT_MUL));
        return ERR_W'(prod >>> SPLIT_SHR);
    endfunction

    function automatic logic [TERM_W-1:0] derive_left(input logic [DERR_W-1:0] d);
        logic [TERM_W-1:0] t;
        t = '0;
        t[TERM_U0_LSB +: ERR_W] = d[DERR_U1_LSB +: ERR_W];
        t[TERM_U1_LSB +: ERR_W] = split_left1(d[DERR_U3_LSB +: ERR_W]);
        t[TERM_V0_LSB +: ERR_W] = d[DERR_V1_LSB +: ERR_W];
        t[TERM_V1_LSB +: ERR_W] = split_left1(d[DERR_V3_LSB +: ERR_W]);
        return t;
    endfunction

    // Remainder of err3 goes down; range is -32..32 so plain truncation is exact.
    function automatic logic [TERM_W-1:0] derive_top(input logic [DERR_W-1:0] d);
        logic [TERM_W-1:0] t;
        t = '0;
        t[TERM_U0_LSB +: ERR_W] = d[DERR_U2_LSB +: ERR_W];
        t[TERM_U1_LSB +: ERR_W] = d[DERR_U3_LSB +: ERR_W] - split_left1(d[DERR_U3_LSB +: ERR_W]);
        t[TERM_V0_LSB +: ERR_W] = d[DERR_V2_LSB +: ERR_W];
        t[TERM_V1_LSB +: ERR_W] = d[DERR_V3_LSB +: ERR_W] - split_left1(d[DERR_V3_LSB +: ERR_W]);
        return t;
    endfunction

endpackage

// File: rtl/dc_derr_store_ram.sv
// Per-column top-error line buffer: simple dual-port, registered 1-cycle read with write-through.
module dc_derr_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rd_zero,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds when re=0; same-edge write to the read address is forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            if (rd_zero) begin
                rdata <= '0;
            end else if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/dc_derr_store.sv
// Chroma DC diffusion-error store: splits each macroblock's U/V DC errors into left/top carries.
// Define DC_DERR_CLEAR_EN to have frame_start zero the whole line buffer (CLEAR state).
module dc_derr_store
    import dc_derr_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store,
    input  logic [ADDR_W-1:0] x,
    input  logic [47:0]       derr,
    input  logic              row_start,
    input  logic              frame_start,
    input  logic              top_derr_en,
    input  logic [ADDR_W-1:0] top_derr_addr,
    output logic [31:0]       top_derr,
    output logic [31:0]       left_derr,
    output logic              busy,
    output logic              done
);

    state_e              state;
    logic [ADDR_W-1:0]   x_q;
    logic [DERR_W-1:0]   derr_q;
    logic [TERM_W-1:0]   left_q;
    logic [TERM_W-1:0]   top_q;

    logic                in_clear_c;
    logic                we_c;
    logic [ADDR_W-1:0]   waddr_c;
    logic [TERM_W-1:0]   wdata_c;

`ifdef DC_DERR_CLEAR_EN
    logic [ADDR_W-1:0]   clr_cnt;

    assign in_clear_c = (state == ST_CLEAR);
    assign waddr_c    = in_clear_c ? clr_cnt : x_q;
    assign wdata_c    = in_clear_c ? '0 : top_q;
`else
    assign in_clear_c = 1'b0;
    assign waddr_c    = x_q;
    assign wdata_c    = top_q;
`endif

    assign we_c = (state == ST_WRITE) || in_clear_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            derr_q    <= '0;
            left_q    <= '0;
            top_q     <= '0;
            left_derr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DC_DERR_CLEAR_EN
            clr_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (row_start || frame_start) begin
                left_derr <= '0;
            end
            case (state)
                // busy also covers the done cycle, so a store there is still refused
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (frame_start) begin
`ifdef DC_DERR_CLEAR_EN
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
`endif
                    end else if (store && !busy) begin
                        state  <= ST_CALC;
                        x_q    <= x;
                        derr_q <= derr;
                        busy   <= 1'b1;
                    end
                end
                ST_CALC: begin
                    left_q <= derive_left(derr_q);
                    top_q  <= derive_top(derr_q);
                    state  <= ST_WRITE;
                end
                // line-buffer write happens on this edge via we_c
                ST_WRITE: begin
                    if (!(row_start || frame_start)) begin
                        left_derr <= left_q;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
`ifdef DC_DERR_CLEAR_EN
                ST_CLEAR: begin
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dc_derr_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (TERM_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we_c),
        .waddr   (waddr_c),
        .wdata   (wdata_c),
        .re      (top_derr_en),
        .raddr   (top_derr_addr),
        .rd_zero (in_clear_c),
        .rdata   (top_derr)
    );

endmodule

// File: tb/tb_dc_derr_store.sv
// Self-checking bench for dc_derr_store: directed scenarios plus random traffic against a timeline model.
module tb_dc_derr_store;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              store = 1'b0;
    logic [ADDR_W-1:0] x = '0;
    logic [47:0]       derr = '0;
    logic              row_start = 1'b0;
    logic              frame_start = 1'b0;
    logic              top_derr_en = 1'b0;
    logic [ADDR_W-1:0] top_derr_addr = '0;
    logic [31:0]       top_derr;
    logic [31:0]       left_derr;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dc_derr_store #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .store         (store),
        .x             (x),
        .derr          (derr),
        .row_start     (row_start),
        .frame_start   (frame_start),
        .top_derr_en   (top_derr_en),
        .top_derr_addr (top_derr_addr),
        .top_derr      (top_derr),
        .left_derr     (left_derr),
        .busy          (busy),
        .done          (done)
    );

    // Reference model: line buffer contents and a timeline of the accepted store.
    logic [31:0]       mem_m [DEPTH];
    bit                known [DEPTH];
    int                edge_n = 0;
    bit                acc_v = 0;
    int                acc_e = 0;
    logic [ADDR_W-1:0] acc_x = '0;
    logic [47:0]       acc_d = '0;
    int                clr_m = 0;
    logic [31:0]       exp_top = '0;
    logic [31:0]       exp_left = '0;
    bit                exp_busy = 0;
    bit                exp_done = 0;
    bit                top_known = 1;

    // Arithmetic view of the split: left = {err1, floor(3*err3/4)}, top = {err2, err3 - left1}.
    function automatic logic [31:0] ref_terms(input logic [47:0] d, input bit want_top);
        logic [31:0] r;
        int e1, e2, e3, l1, t1;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            e1 = int'($signed(d[24*c +: 8]));
            e2 = int'($signed(d[24*c+8 +: 8]));
            e3 = int'($signed(d[24*c+16 +: 8]));
            l1 = (3 * e3) >>> 2;
            t1 = e3 - l1;
            if (want_top) r[16*c +: 16] = {8'(t1), 8'(e2)};
            else          r[16*c +: 16] = {8'(l1), 8'(e1)};
        end
        return r;
    endfunction

    function automatic logic [47:0] rand_derr();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic model_reset();
        acc_v = 0; clr_m = 0;
        exp_top = '0; exp_left = '0; exp_busy = 0; exp_done = 0; top_known = 1;
    endtask

    task automatic model_edge();
        bit wr, clearing, in_flight;
        logic [31:0] wd, ld;
        logic [ADDR_W-1:0] ca;
        clearing  = (clr_m > 0);
        in_flight = acc_v && (edge_n - acc_e >= 1) && (edge_n - acc_e <= 2);
        wr = acc_v && (edge_n == acc_e + 2);
        wd = ref_terms(acc_d, 1);
        ld = ref_terms(acc_d, 0);
        if (top_derr_en) begin
            if (clearing) begin
                exp_top = '0; top_known = 1;
            end else if (wr && top_derr_addr == acc_x) begin
                exp_top = wd; top_known = 1;
            end else begin
                exp_top = mem_m[top_derr_addr]; top_known = known[top_derr_addr];
            end
        end
        if (wr) begin
            mem_m[acc_x] = wd; known[acc_x] = 1;
        end
        if (clearing) begin
            ca = ADDR_W'(DEPTH - clr_m);
            mem_m[ca] = '0; known[ca] = 1;
            clr_m--;
        end
        if (row_start || frame_start) exp_left = '0;
        else if (wr)                  exp_left = ld;
        exp_done = wr;
        if (frame_start) begin
`ifdef DC_DERR_CLEAR_EN
            if (!clearing && !in_flight) clr_m = DEPTH;
`endif
        end else if (store && !exp_busy && !clearing) begin
            acc_v = 1; acc_e = edge_n; acc_x = x; acc_d = derr;
        end
        exp_busy = (acc_v && (edge_n - acc_e <= 2)) || (clr_m > 0);
        edge_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        store = 0; row_start = 0; frame_start = 0; top_derr_en = 0;
        x = '0; derr = '0; top_derr_addr = '0;
    endtask

    task automatic do_store(input logic [ADDR_W-1:0] xa, input logic [47:0] d);
        store = 1; x = xa; derr = d;
        tick();
        store = 0; x = ADDR_W'($urandom_range(0, 15)); derr = rand_derr();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (top_derr !== 32'h0) begin errors++; $display("FAIL reset_top: got %h expected 0", top_derr); end
        checks++; if (left_derr !== 32'h0) begin errors++; $display("FAIL reset_left: got %h expected 0", left_derr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || left_derr !== 32'h0) begin
            errors++; $display("FAIL post_reset_idle: busy=%b done=%b left=%h expected 0/0/0", busy, done, left_derr);
        end
    endtask

    task automatic test_store_example();
        idle_inputs();
        store = 1; x = ADDR_W'(5); derr = 48'h7F0201_80F010;
        tick();
        store = 0; x = ADDR_W'(9); derr = rand_derr();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ex_accept: busy=%b done=%b expected 1/0", busy, done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ex_calc_done: got %b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ex_done: got %b expected 1", done); end
        checks++; if (left_derr !== 32'h5F01A010) begin errors++; $display("FAIL ex_left: got %h expected 5f01a010", left_derr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ex_busy_done_cycle: got %b expected 1", busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ex_after: done=%b busy=%b expected 0/0", done, busy); end
        top_derr_en = 1; top_derr_addr = ADDR_W'(5);
        tick();
        top_derr_en = 0; top_derr_addr = ADDR_W'(1);
        checks++; if (top_derr !== 32'h2002E0F0) begin errors++; $display("FAIL ex_top: got %h expected 2002e0f0", top_derr); end
        tick();
        checks++; if (top_derr !== 32'h2002E0F0) begin errors++; $display("FAIL ex_top_hold: got %h expected 2002e0f0", top_derr); end
    endtask

    task automatic test_bypass();
        logic [47:0] d5, d6;
        d6 = rand_derr();
        d5 = rand_derr();
        do_store(ADDR_W'(6), d6);
        store = 1; x = ADDR_W'(5); derr = d5;
        tick();
        store = 0; derr = rand_derr();
        tick();
        top_derr_en = 1; top_derr_addr = ADDR_W'(5);
        tick();
        top_derr_en = 0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL byp_done: got %b expected 1", done); end
        checks++; if (top_derr !== ref_terms(d5, 1)) begin errors++; $display("FAIL byp_top5: got %h expected %h", top_derr, ref_terms(d5, 1)); end
        top_derr_en = 1; top_derr_addr = ADDR_W'(6);
        tick();
        top_derr_en = 0;
        checks++; if (top_derr !== ref_terms(d6, 1)) begin errors++; $display("FAIL byp_top6: got %h expected %h", top_derr, ref_terms(d6, 1)); end
    endtask

    task automatic test_busy_ignore();
        logic [47:0] da;
        int dones;
        da = rand_derr();
        dones = 0;
        store = 1; x = ADDR_W'(7); derr = da;
        tick();
        derr = ~da;
        for (int i = 0; i < 8; i++) begin
            store = (i < 3);
            tick();
            if (done === 1'b1) dones++;
        end
        store = 0;
        checks++; if (dones != 1) begin errors++; $display("FAIL busy_dones: got %0d expected 1", dones); end
        checks++; if (left_derr !== ref_terms(da, 0)) begin errors++; $display("FAIL busy_left: got %h expected %h", left_derr, ref_terms(da, 0)); end
        top_derr_en = 1; top_derr_addr = ADDR_W'(7);
        tick();
        top_derr_en = 0;
        checks++; if (top_derr !== ref_terms(da, 1)) begin errors++; $display("FAIL busy_top7: got %h expected %h", top_derr, ref_terms(da, 1)); end
    endtask

    task automatic test_row_start();
        logic [47:0] d;
        d = rand_derr();
        d[7:0] = 8'h11;
        store = 1; x = ADDR_W'(3); derr = d;
        tick();
        store = 0;
        tick();
        row_start = 1;
        tick();
        row_start = 0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL row_done: got %b expected 1", done); end
        checks++; if (left_derr !== 32'h0) begin errors++; $display("FAIL row_left: got %h expected 0", left_derr); end
        tick();
        top_derr_en = 1; top_derr_addr = ADDR_W'(3);
        tick();
        top_derr_en = 0;
        checks++; if (top_derr !== ref_terms(d, 1)) begin errors++; $display("FAIL row_top3: got %h expected %h", top_derr, ref_terms(d, 1)); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] d0, d1;
        d0 = rand_derr();
        d1 = ~d0;
        do_store(ADDR_W'(9), d0);
        top_derr_en = 1; top_derr_addr = ADDR_W'(9);
        store = 1; x = ADDR_W'(9); derr = d1;
        tick();
        store = 0; top_derr_en = 0;
        #2 rst_n = 0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || left_derr !== 32'h0 || top_derr !== 32'h0) begin
            errors++; $display("FAIL mid_reset_outputs: busy=%b done=%b left=%h top=%h expected all 0", busy, done, left_derr, top_derr);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        tick();
        top_derr_en = 1; top_derr_addr = ADDR_W'(9);
        tick();
        top_derr_en = 0;
        checks++; if (top_derr !== ref_terms(d0, 1)) begin errors++; $display("FAIL mid_reset_entry: got %h expected %h", top_derr, ref_terms(d0, 1)); end
    endtask

    task automatic test_frame_priority();
        do_store(ADDR_W'(4), rand_derr());
        frame_start = 1; store = 1; x = ADDR_W'(4); derr = rand_derr();
        tick();
        frame_start = 0; store = 0;
        checks++; if (left_derr !== 32'h0) begin errors++; $display("FAIL frame_left: got %h expected 0", left_derr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_drop_store: busy=%b expected 0", busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            store         = ($urandom_range(0, 2) == 0);
            x             = ADDR_W'($urandom_range(0, 15));
            derr          = rand_derr();
            row_start     = ($urandom_range(0, 15) == 0);
`ifdef DC_DERR_CLEAR_EN
            frame_start   = 1'b0;
`else
            frame_start   = ($urandom_range(0, 31) == 0);
`endif
            top_derr_en   = ($urandom_range(0, 1) == 0);
            top_derr_addr = ADDR_W'($urandom_range(0, 15));
            tick();
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy @%0d: got %b expected %b", i, busy, exp_busy); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL rnd_done @%0d: got %b expected %b", i, done, exp_done); end
            checks++; if (left_derr !== exp_left) begin errors++; $display("FAIL rnd_left @%0d: got %h expected %h", i, left_derr, exp_left); end
            if (top_known) begin
                checks++; if (top_derr !== exp_top) begin errors++; $display("FAIL rnd_top @%0d: got %h expected %h", i, top_derr, exp_top); end
            end
        end
        idle_inputs();
        repeat (4) tick();
    endtask

`ifdef DC_DERR_CLEAR_EN
    task automatic test_clear();
        int cyc;
        bit saw_done;
        cyc = 0;
        saw_done = 0;
        frame_start = 1;
        tick();
        frame_start = 0;
        while (busy === 1'b1 && cyc < int'(DEPTH) + 16) begin
            cyc++;
            store = (cyc == 10); x = ADDR_W'(2); derr = rand_derr();
            top_derr_en = (cyc == 20); top_derr_addr = ADDR_W'(6);
            tick();
            if (done === 1'b1) saw_done = 1;
            if (cyc == 20) begin
                checks++; if (top_derr !== 32'h0) begin errors++; $display("FAIL clr_read_during: got %h expected 0", top_derr); end
            end
        end
        store = 0; top_derr_en = 0;
        checks++; if (cyc != int'(DEPTH)) begin errors++; $display("FAIL clr_busy_len: got %0d expected %0d", cyc, DEPTH); end
        checks++; if (saw_done) begin errors++; $display("FAIL clr_done: got pulse expected none"); end
        for (int a = 0; a < 17; a++) begin
            top_derr_en = 1;
            top_derr_addr = (a == 16) ? ADDR_W'(DEPTH - 1) : ADDR_W'(a);
            tick();
            checks++; if (top_derr !== 32'h0) begin errors++; $display("FAIL clr_entry %0d: got %h expected 0", top_derr_addr, top_derr); end
        end
        top_derr_en = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_store_example();
        test_bypass();
        test_busy_ignore();
        test_row_start();
        test_reset_mid();
`ifndef DC_DERR_CLEAR_EN
        test_frame_priority();
`endif
        test_random();
`ifdef DC_DERR_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
